// File: rtl/matrix_operand_store_pkg.sv
// Shared constants, FSM state type and index helpers for the matrix operand store.
package matrix_operand_store_pkg;

    localparam int unsigned DEF_MAX_ROWS = 5;
    localparam int unsigned DEF_MAX_COLS = 5;
    localparam int unsigned DEF_DW       = 32;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned CNT_W        = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DUMP = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // True when an index addresses a real row/column (0 .. lim-1).
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx, input int unsigned lim);
        return (32'(idx) < lim);
    endfunction

    // True when a dump dimension is between 1 and lim inclusive.
    function automatic logic dim_ok(input logic [IDX_W-1:0] dim, input int unsigned lim);
        return (dim != '0) && (32'(dim) <= lim);
    endfunction

endpackage

// File: rtl/matrix_plane.sv
// One ROWS x COLS x DW operand plane: async clear, one synchronous write port,
// one combinational read port returning 0 for out-of-range addresses.
module matrix_plane
    import matrix_operand_store_pkg::*;
#(
    parameter int unsigned ROWS = DEF_MAX_ROWS,
    parameter int unsigned COLS = DEF_MAX_COLS,
    parameter int unsigned DW   = DEF_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [IDX_W-1:0] wr_col,
    input  logic [DW-1:0]    wr_data,
    input  logic [IDX_W-1:0] rd_row,
    input  logic [IDX_W-1:0] rd_col,
    output logic [DW-1:0]    rd_data
);

    logic [DW-1:0] mem_q [ROWS][COLS];

    // Cell storage: cleared on reset, written at the addressed cell when we is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (we) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (wr_row == IDX_W'(r) && wr_col == IDX_W'(c)) begin
                        mem_q[r][c] <= wr_data;
                    end
                end
            end
        end
    end

    // Read mux: an address matching no cell falls through to zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (rd_row == IDX_W'(r) && rd_col == IDX_W'(c)) begin
                    rd_data = mem_q[r][c];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_operand_store.sv
// Memory-side responder for the matrix ALU: operand planes A/B filled by a
// loader, result plane C captured from the ALU and streamed row-major on demand.
module matrix_operand_store
    import matrix_operand_store_pkg::*;
#(
    parameter int unsigned MAX_ROWS = DEF_MAX_ROWS,
    parameter int unsigned MAX_COLS = DEF_MAX_COLS,
    parameter int unsigned DW       = DEF_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_we,
    input  logic             load_sel,
    input  logic [IDX_W-1:0] load_row,
    input  logic [IDX_W-1:0] load_col,
    input  logic [DW-1:0]    load_data,
    input  logic [IDX_W-1:0] row_read_a,
    input  logic [IDX_W-1:0] col_read_a,
    input  logic [IDX_W-1:0] row_read_b,
    input  logic [IDX_W-1:0] col_read_b,
    output logic [DW-1:0]    data_a,
    output logic [DW-1:0]    data_b,
    input  logic [DW-1:0]    result,
    input  logic [IDX_W-1:0] row_write,
    input  logic [IDX_W-1:0] col_write,
    input  logic             result_we,
    input  logic             c_clear,
    input  logic             dump_start,
    input  logic [IDX_W-1:0] dump_rows,
    input  logic [IDX_W-1:0] dump_cols,
    output logic [DW-1:0]    out_data,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             dump_done,
    output logic             busy,
    output logic [CNT_W-1:0] written_cnt,
    output logic             err
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] r_q, r_d, c_q, c_d;
    logic [IDX_W-1:0] rows_q, rows_d, cols_q, cols_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bm_q [MAX_ROWS][MAX_COLS];
    logic             bm_d [MAX_ROWS][MAX_COLS];

    logic             load_ok, res_ok;
    logic             we_a, we_b, res_accept;
    logic             load_bad, res_bad, dims_bad;
    logic             at_last;
    logic [DW-1:0]    c_rd_data;

    assign load_ok    = idx_ok(load_row, MAX_ROWS) && idx_ok(load_col, MAX_COLS);
    assign res_ok     = idx_ok(row_write, MAX_ROWS) && idx_ok(col_write, MAX_COLS);
    assign we_a       = load_we && load_ok && !load_sel;
    assign we_b       = load_we && load_ok && load_sel;
    // Results are refused while streaming so the dumped data cannot change underneath.
    assign res_accept = result_we && res_ok && (state_q != S_DUMP);
    assign load_bad   = load_we && !load_ok;
    assign res_bad    = result_we && !res_accept;
    assign err_d      = load_bad || res_bad || dims_bad;

    assign at_last    = (r_q == (rows_q - 4'd1)) && (c_q == (cols_q - 4'd1));

    assign out_row     = r_q;
    assign out_col     = c_q;
    assign out_data    = out_valid ? c_rd_data : '0;
    assign written_cnt = cnt_q;
    assign err         = err_q;

    matrix_plane #(.ROWS(MAX_ROWS), .COLS(MAX_COLS), .DW(DW)) u_plane_a (
        .clk     (clk),
        .rst     (rst),
        .we      (we_a),
        .wr_row  (load_row),
        .wr_col  (load_col),
        .wr_data (load_data),
        .rd_row  (row_read_a),
        .rd_col  (col_read_a),
        .rd_data (data_a)
    );

    matrix_plane #(.ROWS(MAX_ROWS), .COLS(MAX_COLS), .DW(DW)) u_plane_b (
        .clk     (clk),
        .rst     (rst),
        .we      (we_b),
        .wr_row  (load_row),
        .wr_col  (load_col),
        .wr_data (load_data),
        .rd_row  (row_read_b),
        .rd_col  (col_read_b),
        .rd_data (data_b)
    );

    // Plane C's only read port is driven by the stream cursor.
    matrix_plane #(.ROWS(MAX_ROWS), .COLS(MAX_COLS), .DW(DW)) u_plane_c (
        .clk     (clk),
        .rst     (rst),
        .we      (res_accept),
        .wr_row  (row_write),
        .wr_col  (col_write),
        .wr_data (result),
        .rd_row  (r_q),
        .rd_col  (c_q),
        .rd_data (c_rd_data)
    );

    // Written-cell bitmap and count; a clear is applied before the same-cycle write.
    always_comb begin
        bm_d  = bm_q;
        cnt_d = cnt_q;
        if (c_clear) begin
            for (int unsigned r = 0; r < MAX_ROWS; r++) begin
                for (int unsigned c = 0; c < MAX_COLS; c++) begin
                    bm_d[r][c] = 1'b0;
                end
            end
            cnt_d = '0;
        end
        if (res_accept) begin
            for (int unsigned r = 0; r < MAX_ROWS; r++) begin
                for (int unsigned c = 0; c < MAX_COLS; c++) begin
                    if (row_write == IDX_W'(r) && col_write == IDX_W'(c) && !bm_d[r][c]) begin
                        bm_d[r][c] = 1'b1;
                        cnt_d      = cnt_d + 5'd1;
                    end
                end
            end
        end
    end

    // Dump FSM next state and stream outputs.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        dims_bad  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        dump_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    if (dim_ok(dump_rows, MAX_ROWS) && dim_ok(dump_cols, MAX_COLS)) begin
                        rows_d  = dump_rows;
                        cols_d  = dump_cols;
                        r_d     = '0;
                        c_d     = '0;
                        state_d = S_DUMP;
                    end else begin
                        dims_bad = 1'b1;
                        state_d  = S_FIN;
                    end
                end
            end
            S_DUMP: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = at_last;
                if (out_ready) begin
                    if (c_q == (cols_q - 4'd1)) begin
                        c_d = '0;
                        if (at_last) begin
                            r_d     = '0;
                            state_d = S_FIN;
                        end else begin
                            r_d = r_q + 4'd1;
                        end
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end
            S_FIN: begin
                dump_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers: FSM, stream cursor, latched dimensions, error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            err_q   <= err_d;
        end
    end

    // Bitmap and written-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int unsigned r = 0; r < MAX_ROWS; r++) begin
                for (int unsigned c = 0; c < MAX_COLS; c++) begin
                    bm_q[r][c] <= 1'b0;
                end
            end
        end else begin
            cnt_q <= cnt_d;
            bm_q  <= bm_d;
        end
    end

endmodule

// File: tb/tb_matrix_operand_store.sv
// Self-checking bench for matrix_operand_store: directed vector table, directed
// dump sequences and randomized traffic checked against an array-based model.
module tb_matrix_operand_store;

    localparam int NR = 5;
    localparam int NC = 5;

    logic        clk;
    logic        rst;
    logic        load_we, load_sel;
    logic [3:0]  load_row, load_col;
    logic [31:0] load_data;
    logic [3:0]  row_read_a, col_read_a, row_read_b, col_read_b;
    logic [31:0] data_a, data_b;
    logic [31:0] result;
    logic [3:0]  row_write, col_write;
    logic        result_we, c_clear, dump_start;
    logic [3:0]  dump_rows, dump_cols;
    logic [31:0] out_data;
    logic [3:0]  out_row, out_col;
    logic        out_valid, out_ready, out_last, dump_done, busy;
    logic [4:0]  written_cnt;
    logic        err;

    matrix_operand_store #(.MAX_ROWS(5), .MAX_COLS(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_sel(load_sel), .load_row(load_row), .load_col(load_col),
        .load_data(load_data),
        .row_read_a(row_read_a), .col_read_a(col_read_a),
        .row_read_b(row_read_b), .col_read_b(col_read_b),
        .data_a(data_a), .data_b(data_b),
        .result(result), .row_write(row_write), .col_write(col_write), .result_we(result_we),
        .c_clear(c_clear), .dump_start(dump_start), .dump_rows(dump_rows), .dump_cols(dump_cols),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .dump_done(dump_done), .busy(busy),
        .written_cnt(written_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mA [NR][NC];
    logic [31:0] mB [NR][NC];
    logic [31:0] mC [NR][NC];
    bit          mbm [NR][NC];
    int          mcnt;

    typedef struct {
        int          r;
        int          c;
        logic [31:0] ea;
        logic [31:0] eb;
    } rdvec_t;

    rdvec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                mA[r][c] = '0; mB[r][c] = '0; mC[r][c] = '0; mbm[r][c] = 0;
            end
        mcnt = 0;
    endtask

    function automatic logic [31:0] mread(input bit planeb, input int r, input int c);
        if (r >= NR || c >= NC) return '0;
        return planeb ? mB[r][c] : mA[r][c];
    endfunction

    // One idle-state clock with optional load, result write and clear.
    task automatic do_cycle(input bit lw, input bit lsel, input int lr, input int lc,
                            input logic [31:0] ld, input bit rw, input int rr, input int rc,
                            input logic [31:0] rd, input bit clr);
        bit lerr, rerr;
        load_we = lw; load_sel = lsel; load_row = 4'(lr); load_col = 4'(lc); load_data = ld;
        result_we = rw; row_write = 4'(rr); col_write = 4'(rc); result = rd; c_clear = clr;
        lerr = lw && (lr >= NR || lc >= NC);
        rerr = rw && (rr >= NR || rc >= NC);
        if (lw && !lerr) begin
            if (lsel) mB[lr][lc] = ld; else mA[lr][lc] = ld;
        end
        if (clr) begin
            for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) mbm[r][c] = 0;
            mcnt = 0;
        end
        if (rw && !rerr) begin
            mC[rr][rc] = rd;
            if (!mbm[rr][rc]) begin mbm[rr][rc] = 1; mcnt++; end
        end
        tick();
        load_we = 0; result_we = 0; c_clear = 0;
        check("cycle_err", 32'(err), 32'(lerr || rerr));
        check("written_cnt", 32'(written_cnt), 32'(mcnt));
    endtask

    // Stream a rows x cols dump; mode 0 ready high, 1 pattern 1,0,0, 2 random.
    task automatic do_dump(input int rows, input int cols, input int mode, input bit inject);
        logic [31:0] ed [25];
        int er [25];
        int ec [25];
        int n, idx, cyc;
        bit rdy, errn;
        dump_rows = 4'(rows); dump_cols = 4'(cols); dump_start = 1;
        tick();
        dump_start = 0;
        if (!(rows >= 1 && rows <= NR && cols >= 1 && cols <= NC)) begin
            check("bad_dim_err", 32'(err), 32'd1);
            check("bad_dim_valid", 32'(out_valid), 32'd0);
            check("bad_dim_done", 32'(dump_done), 32'd1);
            tick();
            check("bad_dim_done_clr", 32'(dump_done), 32'd0);
            check("bad_dim_busy", 32'(busy), 32'd0);
            return;
        end
        n = 0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                ed[n] = mC[r][c]; er[n] = r; ec[n] = c; n++;
            end
        idx = 0; cyc = 0; errn = 0;
        while (idx < n && cyc < 40 * n) begin
            check("dump_valid", 32'(out_valid), 32'd1);
            check("dump_busy", 32'(busy), 32'd1);
            check("dump_err", 32'(err), 32'(errn));
            check("beat_data", out_data, ed[idx]);
            check("beat_row", 32'(out_row), 32'(er[idx]));
            check("beat_col", 32'(out_col), 32'(ec[idx]));
            check("beat_last", 32'(out_last), 32'(idx == n - 1));
            case (mode)
                0:       rdy = 1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (inject && cyc == 0) begin
                rdy = 0; result_we = 1; row_write = 0; col_write = 0; result = 32'hDEADBEEF;
            end
            out_ready = rdy;
            tick();
            result_we = 0;
            errn = inject && (cyc == 0);
            if (rdy) idx++;
            cyc++;
        end
        check("dump_beats", 32'(idx), 32'(n));
        check("fin_done", 32'(dump_done), 32'd1);
        check("fin_valid", 32'(out_valid), 32'd0);
        check("fin_err", 32'(err), 32'(errn));
        out_ready = 0;
        tick();
        check("idle_done", 32'(dump_done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("dump_cnt", 32'(written_cnt), 32'(mcnt));
    endtask

    initial begin
        rst = 1;
        load_we = 0; load_sel = 0; load_row = 0; load_col = 0; load_data = 0;
        row_read_a = 0; col_read_a = 0; row_read_b = 0; col_read_b = 0;
        result = 0; row_write = 0; col_write = 0; result_we = 0; c_clear = 0;
        dump_start = 0; dump_rows = 0; dump_cols = 0; out_ready = 0;
        model_reset();

        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_row", 32'(out_row), 32'd0);
        check("rst_col", 32'(out_col), 32'd0);
        check("rst_cnt", 32'(written_cnt), 32'd0);
        #10;
        rst = 0;
        tick();

        // Operand loads, including out-of-range rejections
        do_cycle(1, 0, 1, 2, 32'h0000_0007, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 1, 2, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 4, 4, 32'h0000_A5A5, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 0, 4, 32'h1234_5678, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 5, 1, 32'h0000_0BAD, 0, 0, 0, 0, 0);
        do_cycle(1, 1, 2, 7, 32'h0000_0BAD, 0, 0, 0, 0, 0);

        // Directed read table
        vt[0] = '{1, 2, 32'h0000_0007, 32'hFFFF_FFFE};
        vt[1] = '{5, 0, 32'h0,         32'h0};
        vt[2] = '{0, 5, 32'h0,         32'h0};
        vt[3] = '{4, 4, 32'h0000_A5A5, 32'h0};
        vt[4] = '{0, 4, 32'h0,         32'h1234_5678};
        vt[5] = '{15, 15, 32'h0,       32'h0};
        for (int i = 0; i < 6; i++) begin
            row_read_a = 4'(vt[i].r); col_read_a = 4'(vt[i].c);
            row_read_b = 4'(vt[i].r); col_read_b = 4'(vt[i].c);
            #1;
            check("vec_data_a", data_a, vt[i].ea);
            check("vec_data_b", data_b, vt[i].eb);
        end

        // 2x2 result capture and dumps
        do_cycle(0, 0, 0, 0, 0, 1, 0, 0, 32'd11, 0);
        do_cycle(0, 0, 0, 0, 0, 1, 0, 1, 32'd12, 0);
        do_cycle(0, 0, 0, 0, 0, 1, 1, 0, 32'd21, 0);
        do_cycle(0, 0, 0, 0, 0, 1, 1, 1, 32'd22, 0);
        check("cnt_after_2x2", 32'(written_cnt), 32'd4);
        do_dump(2, 2, 0, 0);
        do_dump(2, 2, 1, 0);
        do_dump(0, 3, 0, 0);
        do_dump(6, 1, 0, 0);
        do_dump(2, 2, 0, 1);

        // Rewrite, simultaneous load+result, clears, out-of-range result
        do_cycle(0, 0, 0, 0, 0, 1, 0, 0, 32'd99, 0);
        do_cycle(1, 0, 3, 3, 32'h55, 1, 3, 3, 32'h66, 0);
        row_read_a = 3; col_read_a = 3;
        #1;
        check("same_cycle_load", data_a, 32'h55);
        do_dump(4, 4, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_cycle(0, 0, 0, 0, 0, 1, 2, 2, 32'h77, 1);
        do_cycle(0, 0, 0, 0, 0, 1, 5, 0, 32'h88, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), $urandom,
                     1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), $urandom,
                     ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 30; i++) begin
            int ra, ca, rb, cb;
            ra = int'($urandom_range(0, 6)); ca = int'($urandom_range(0, 6));
            rb = int'($urandom_range(0, 6)); cb = int'($urandom_range(0, 6));
            row_read_a = 4'(ra); col_read_a = 4'(ca); row_read_b = 4'(rb); col_read_b = 4'(cb);
            #1;
            check("rand_data_a", data_a, mread(0, ra, ca));
            check("rand_data_b", data_b, mread(1, rb, cb));
        end
        for (int i = 0; i < 5; i++) begin
            do_dump(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 2,
                    1'($urandom_range(0, 1)));
        end

        // Reset at the second beat of a 3x3 dump
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                do_cycle(0, 0, 0, 0, 0, 1, r, c, 32'(100 + r * 10 + c), 0);
        dump_rows = 3; dump_cols = 3; dump_start = 1; out_ready = 1;
        tick();
        dump_start = 0;
        check("abort_beat0", out_data, 32'd100);
        tick();
        check("abort_beat1_col", 32'(out_col), 32'd1);
        check("abort_beat1", out_data, 32'd101);
        rst = 1;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(dump_done), 32'd0);
        model_reset();
        out_ready = 0;
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 32'(dump_done), 32'd0);
        end
        check("abort_cnt", 32'(written_cnt), 32'd0);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                row_read_a = 4'(r); col_read_a = 4'(c); row_read_b = 4'(r); col_read_b = 4'(c);
                #1;
                check("post_rst_a", data_a, 32'd0);
                check("post_rst_b", data_b, 32'd0);
            end
        do_dump(5, 5, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matrix_operand_store.md
Name: matrix_operand_store

Overview:
- Memory-side responder for the matrix ALU.
- Holds operand planes A and B, which a loader port fills.
- Answers the ALU's row/column read addresses with operand data in the same cycle.
- Captures ALU result writes into plane C, then streams C row-major to a downstream consumer (display/UART formatter) over a valid/ready handshake.

Parameters:
- MAX_ROWS, 5, row capacity per plane (shared constant from parameters.vh).
- MAX_COLS, 5, column capacity per plane (shared constant from parameters.vh).
- DW, 32, element width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load_we  in  1  write one element into A or B
- load_sel  in  1  0=A, 1=B
- load_row  in  4  loader row index
- load_col  in  4  loader column index
- load_data  in  DW  loader element
- row_read_a  in  4  ALU read row, plane A
- col_read_a  in  4  ALU read column, plane A
- row_read_b  in  4  ALU read row, plane B
- col_read_b  in  4  ALU read column, plane B
- data_a  out  DW  A[row_read_a][col_read_a], combinational
- data_b  out  DW  B[row_read_b][col_read_b], combinational
- result  in  DW  ALU result element
- row_write  in  4  ALU result row
- col_write  in  4  ALU result column
- result_we  in  1  ALU result write strobe
- c_clear  in  1  clear plane-C written bitmap and count
- dump_start  in  1  request a stream of C
- dump_rows  in  4  rows to stream, latched on accept
- dump_cols  in  4  columns to stream, latched on accept
- out_data  out  DW  streamed element
- out_row  out  4  row index of streamed element
- out_col  out  4  column index of streamed element
- out_valid  out  1  stream valid
- out_ready  in  1  consumer ready
- out_last  out  1  final element of the stream
- dump_done  out  1  one-cycle pulse when a dump finishes
- busy  out  1  high while in S_DUMP
- written_cnt  out  5  number of distinct C cells written since clear
- err  out  1  one-cycle pulse on a rejected access

Behaviour:
- Reset (async): A, B and C all zero; bitmap zero; written_cnt=0; state S_IDLE.
- Reset values: out_valid=0, out_last=0, dump_done=0, busy=0, err=0, out_row=0, out_col=0.
- Reset mid-dump: the stream aborts immediately; no dump_done is issued.
- ALU reads: purely combinational, zero latency, matching the ALU's register-address/consume-next-edge timing. An index at or beyond MAX_ROWS/MAX_COLS returns 0.
- Loader: a write occurs at the clock edge when load_we=1.
  - Out-of-range index: write dropped, err pulses.
  - A load and a result_we in the same cycle both take effect, because they target different planes.
- Result capture, when result_we=1 and the index is in range:
  - C[row][col] <= result.
  - If the cell was not yet written, set its bitmap bit and increment written_cnt. Rewriting a cell does not increment.
  - Out of range: dropped, err pulses.
- result_we during S_DUMP: dropped and err pulses. This keeps streamed data stable.
- c_clear: zeroes the bitmap and written_cnt only; C data is kept. If c_clear and result_we arrive together, the clear applies first, so the new write counts as 1.
- FSM states: S_IDLE, S_DUMP, S_FIN.
- S_IDLE:
  - On dump_start with 1<=dump_rows<=MAX_ROWS and 1<=dump_cols<=MAX_COLS: latch the dimensions, set r=c=0, go to S_DUMP.
  - On dump_start with invalid dimensions: err pulses and the FSM goes to S_FIN with no beats.
  - dump_start is ignored outside S_IDLE.
- S_DUMP:
  - busy=1 and out_valid=1.
  - out_data=C[r][c], out_row=r, out_col=c.
  - out_last=1 when r=rows-1 and c=cols-1.
  - On out_valid&&out_ready: advance c, wrapping to 0 with r+1. After the last beat go to S_FIN.
  - With out_ready=0, all out_* signals hold stable.
  - The first beat is presented the cycle after dump_start is accepted.
- S_FIN: dump_done=1 for one cycle, then S_IDLE.
- A dump of R×C elements with out_ready held high takes R*C cycles of valid, then one dump_done cycle.
- No arithmetic is performed. Data passes through untouched at DW bits.

Decomposition:
- parameters.vh holds MAX_ROWS, MAX_COLS, DW, and the state encodings S_IDLE/S_DUMP/S_FIN.
- One natural sub-module: matrix_plane. It is an MAX_ROWS×MAX_COLS×DW register array with async clear, one synchronous write port, and one combinational read port that returns 0 out of range. It is instantiated three times, and C's read port is shared by the dump logic.
- The bitmap, written_cnt and the FSM stay in the top module.

Test Plan:
- Load A[1][2]=0x00000007 and B[1][2]=0xFFFFFFFE; drive read addresses (1,2) -> data_a=7 and data_b=0xFFFFFFFE in the same cycle. Drive read address (5,0) -> data_a=0.
- Write a 2×2 result (11,12,21,22) via result_we, then dump_start with 2×2 and out_ready=1 -> 4 valid cycles with data 11,12,21,22 and (row,col) (0,0),(0,1),(1,0),(1,1); out_last only on the 4th; dump_done on the next cycle; written_cnt=4.
- Same dump with out_ready toggling 1,0,0,1,... -> no element is skipped or duplicated, and outputs stay stable while stalled.
- dump_start with dims 0×3 and with 6×1 -> err pulse, no out_valid, dump_done one cycle later.
- result_we to (0,0) during S_DUMP -> err pulse, C unchanged. Rewrite an already-written cell in S_IDLE -> written_cnt unchanged. Assert c_clear -> written_cnt=0.
- Assert rst at the 2nd beat of a 3×3 dump -> out_valid=0, busy=0, no dump_done, and all planes read 0 after reset.
